// File: rtl/lint_apb_arb_if.sv
// Upstream LINT master array plus downstream bridge port of the LINT-to-APB arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric's view.
interface lint_apb_arb_if #(
    parameter int NB_MASTER  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 10,
    parameter int AUX_WIDTH  = 14
);
    logic [NB_MASTER-1:0]                 m_req_i;
    logic [NB_MASTER-1:0][ADDR_WIDTH-1:0] m_add_i;
    logic [NB_MASTER-1:0]                 m_we_n_i;
    logic [NB_MASTER-1:0][DATA_WIDTH-1:0] m_wdata_i;
    logic [NB_MASTER-1:0][BE_WIDTH-1:0]   m_be_i;
    logic [NB_MASTER-1:0][AUX_WIDTH-1:0]  m_aux_i;
    logic [NB_MASTER-1:0][ID_WIDTH-1:0]   m_ID_i;
    logic [NB_MASTER-1:0]                 m_gnt_o;

    logic [NB_MASTER-1:0]                 m_r_valid_o;
    logic [DATA_WIDTH-1:0]                m_r_rdata_o;
    logic                                 m_r_opc_o;
    logic [AUX_WIDTH-1:0]                 m_r_aux_o;
    logic [ID_WIDTH-1:0]                  m_r_ID_o;

    logic                                 s_req_o;
    logic [ADDR_WIDTH-1:0]                s_add_o;
    logic                                 s_we_n_o;
    logic [DATA_WIDTH-1:0]                s_wdata_o;
    logic [BE_WIDTH-1:0]                  s_be_o;
    logic [AUX_WIDTH-1:0]                 s_aux_o;
    logic [ID_WIDTH-1:0]                  s_ID_o;
    logic                                 s_gnt_i;
    logic                                 s_r_valid_i;
    logic [DATA_WIDTH-1:0]                s_r_rdata_i;
    logic                                 s_r_opc_i;
    logic [AUX_WIDTH-1:0]                 s_r_aux_i;
    logic [ID_WIDTH-1:0]                  s_r_ID_i;

    modport slave (
        input  m_req_i, m_add_i, m_we_n_i, m_wdata_i, m_be_i, m_aux_i, m_ID_i,
        output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o, m_r_aux_o, m_r_ID_o,
        output s_req_o, s_add_o, s_we_n_o, s_wdata_o, s_be_o, s_aux_o, s_ID_o,
        input  s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i, s_r_aux_i, s_r_ID_i
    );

    modport master (
        output m_req_i, m_add_i, m_we_n_i, m_wdata_i, m_be_i, m_aux_i, m_ID_i,
        input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o, m_r_aux_o, m_r_ID_o,
        input  s_req_o, s_add_o, s_we_n_o, s_wdata_o, s_be_o, s_aux_o, s_ID_o,
        output s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i, s_r_aux_i, s_r_ID_i
    );
endinterface

// File: rtl/lint_apb_arb.sv
// Round-robin arbiter sharing one single-outstanding LINT-to-APB bridge between
// NB_MASTER requesters; the response is routed back to the recorded owner only.
module lint_apb_arb #(
    parameter int NB_MASTER  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 10,
    parameter int AUX_WIDTH  = 14
) (
    input logic          clk,
    input logic          rst,
    lint_apb_arb_if.slave bus
);
    localparam int RRW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

    typedef enum logic [1:0] {IDLE, LOCK, BUSY} state_t;

    state_t         state_q;
    logic [RRW-1:0] rr_q, lock_q, owner_q;
    logic [RRW-1:0] win, sel;
    logic           any_req, s_req;

    function automatic logic [RRW-1:0] wrap_inc(input logic [RRW-1:0] i);
        return RRW'((int'(i) + 1) % NB_MASTER);
    endfunction

    // Scan from the farthest candidate down so the one nearest rr_q wins.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        any_req = 1'b0;
        for (int k = NB_MASTER - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NB_MASTER;
            if (bus.m_req_i[idx]) begin
                win     = RRW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign sel = (state_q == LOCK) ? lock_q : win;

    always_comb begin
        s_req = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    s_req = any_req;
                LOCK:    s_req = bus.m_req_i[lock_q];
                default: s_req = 1'b0;
            endcase
        end
    end

    assign bus.s_req_o   = s_req;
    assign bus.s_add_o   = bus.m_add_i[sel];
    assign bus.s_we_n_o  = bus.m_we_n_i[sel];
    assign bus.s_wdata_o = bus.m_wdata_i[sel];
    assign bus.s_be_o    = bus.m_be_i[sel];
    assign bus.s_aux_o   = bus.m_aux_i[sel];
    assign bus.s_ID_o    = bus.m_ID_i[sel];

    always_comb begin
        bus.m_gnt_o = '0;
        if (s_req && bus.s_gnt_i)
            bus.m_gnt_o[sel] = 1'b1;
    end

    always_comb begin
        bus.m_r_valid_o = '0;
        if (!rst && state_q == BUSY && bus.s_r_valid_i)
            bus.m_r_valid_o[owner_q] = 1'b1;
    end

    assign bus.m_r_rdata_o = bus.s_r_rdata_i;
    assign bus.m_r_opc_o   = bus.s_r_opc_i;
    assign bus.m_r_aux_o   = bus.s_r_aux_i;
    assign bus.m_r_ID_o    = bus.s_r_ID_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
            owner_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    if (bus.s_gnt_i) begin
                        owner_q <= win;
                        rr_q    <= wrap_inc(win);
                        state_q <= BUSY;
                    end else begin
                        lock_q  <= win;
                        state_q <= LOCK;
                    end
                end
                // A withdrawn request leaves the lock without a grant.
                LOCK: if (!bus.m_req_i[lock_q]) begin
                    state_q <= IDLE;
                end else if (bus.s_gnt_i) begin
                    owner_q <= lock_q;
                    rr_q    <= wrap_inc(lock_q);
                    state_q <= BUSY;
                end
                BUSY: if (bus.s_r_valid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lint_apb_arb.sv
// Self-checking bench for lint_apb_arb: vector table, directed sequences and a
// randomized run against an integer-level reference model.
module tb_lint_apb_arb;
    localparam int N = 4, AW = 32, DW = 32, BW = 4, IW = 10, XW = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lint_apb_arb_if #(.NB_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .BE_WIDTH(BW), .ID_WIDTH(IW), .AUX_WIDTH(XW)) bus();

    lint_apb_arb #(.NB_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .BE_WIDTH(BW), .ID_WIDTH(IW), .AUX_WIDTH(XW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_req_i     = '0;
        bus.m_we_n_i    = '1;
        bus.m_be_i      = '0;
        bus.m_aux_i     = '0;
        bus.m_ID_i      = '0;
        bus.m_wdata_i   = '0;
        for (int i = 0; i < N; i++) bus.m_add_i[i] = 32'h1000 + 32'(i);
        bus.s_gnt_i     = 1'b0;
        bus.s_r_valid_i = 1'b0;
        bus.s_r_rdata_i = '0;
        bus.s_r_opc_i   = 1'b0;
        bus.s_r_aux_i   = '0;
        bus.s_r_ID_i    = '0;
    endtask

    // Hold reset for one edge with live requests and grant to prove outputs are forced low.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        bus.m_req_i = 4'b1111;
        bus.s_gnt_i = 1'b1;
        bus.s_r_valid_i = 1'b1;
        #1;
        chk("rst_s_req", 64'(bus.s_req_o), 64'd0);
        chk("rst_gnt", 64'(bus.m_gnt_o), 64'd0);
        chk("rst_rvalid", 64'(bus.m_r_valid_o), 64'd0);
        tick();
        rst = 1'b0;
        clear_inputs();
        chk("rst_rr", 64'(dut.rr_q), 64'd0);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       sg;
        logic       rv;
        logic       e_sreq;
        logic [3:0] e_gnt;
        logic [3:0] e_rv;
        int         e_rr;
        int         e_sel;
    } vec_t;

    vec_t tbl[21];

    // Reference model state
    int  m_busy, m_pres, m_rr, m_owner;
    int  e_sel, w;
    logic e_sreq;
    logic [3:0] e_gnt, e_rv;

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        do_reset();

        //          rst req     sg rv sreq gnt     rv      rr sel
        tbl[0]  = '{0, 4'b0100, 1, 0, 1, 4'b0100, 4'b0000, 0, 2};
        tbl[1]  = '{0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 3, -1};
        tbl[2]  = '{0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 3, -1};
        tbl[3]  = '{0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0100, 3, -1};
        tbl[4]  = '{0, 4'b0010, 0, 0, 1, 4'b0000, 4'b0000, 3, 1};
        tbl[5]  = '{0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 3, -1};
        tbl[6]  = '{0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 3, -1};
        tbl[7]  = '{0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 3, -1};
        tbl[8]  = '{0, 4'b0001, 1, 0, 1, 4'b0001, 4'b0000, 3, 0};
        tbl[9]  = '{1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, -1};
        tbl[10] = '{0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, -1};
        tbl[11] = '{0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, -1};
        tbl[12] = '{0, 4'b0001, 1, 0, 1, 4'b0001, 4'b0000, 0, 0};
        tbl[13] = '{0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0001, 1, -1};
        tbl[14] = '{0, 4'b0010, 0, 0, 1, 4'b0000, 4'b0000, 1, 1};
        tbl[15] = '{0, 4'b0011, 0, 0, 1, 4'b0000, 4'b0000, 1, 1};
        tbl[16] = '{0, 4'b0011, 0, 0, 1, 4'b0000, 4'b0000, 1, 1};
        tbl[17] = '{0, 4'b0011, 1, 0, 1, 4'b0010, 4'b0000, 1, 1};
        tbl[18] = '{0, 4'b0001, 0, 1, 0, 4'b0000, 4'b0010, 2, -1};
        tbl[19] = '{0, 4'b0001, 1, 0, 1, 4'b0001, 4'b0000, 2, 0};
        tbl[20] = '{0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0001, 1, -1};

        for (int i = 0; i < 21; i++) begin
            rst             = tbl[i].rst;
            bus.m_req_i     = tbl[i].req;
            bus.s_gnt_i     = tbl[i].sg;
            bus.s_r_valid_i = tbl[i].rv;
            #2;
            chk($sformatf("tbl%0d_s_req", i), 64'(bus.s_req_o), 64'(tbl[i].e_sreq));
            chk($sformatf("tbl%0d_gnt", i), 64'(bus.m_gnt_o), 64'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d_rvalid", i), 64'(bus.m_r_valid_o), 64'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_rr", i), 64'(dut.rr_q), 64'(tbl[i].e_rr));
            if (tbl[i].e_sel >= 0)
                chk($sformatf("tbl%0d_addr", i), 64'(bus.s_add_o), 64'(32'h1000 + tbl[i].e_sel));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        clear_inputs();

        // All four masters request continuously; one outstanding at a time.
        do_reset();
        bus.m_req_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            bus.s_gnt_i = 1'b1; bus.s_r_valid_i = 1'b0;
            #1;
            chk($sformatf("rr%0d_gnt", k), 64'(bus.m_gnt_o), 64'(1) << (k % 4));
            tick();
            #1;
            chk($sformatf("rr%0d_busy_gnt", k), 64'(bus.m_gnt_o), 64'd0);
            chk($sformatf("rr%0d_busy_sreq", k), 64'(bus.s_req_o), 64'd0);
            tick();
            bus.s_r_valid_i = 1'b1;
            #1;
            chk($sformatf("rr%0d_rsp_gnt", k), 64'(bus.m_gnt_o), 64'd0);
            chk($sformatf("rr%0d_rvalid", k), 64'(bus.m_r_valid_o), 64'(1) << (k % 4));
            tick();
        end
        clear_inputs();

        // Master 3 write with error response; full field check.
        bus.m_req_i      = 4'b1000;
        bus.m_add_i[3]   = 32'h1A10_0004;
        bus.m_we_n_i[3]  = 1'b0;
        bus.m_wdata_i[3] = 32'h1234_5678;
        bus.m_be_i[3]    = 4'hF;
        bus.m_ID_i[3]    = 10'h2A;
        bus.m_aux_i[3]   = 14'h155;
        bus.s_gnt_i      = 1'b1;
        #1;
        chk("wr_gnt", 64'(bus.m_gnt_o), 64'b1000);
        chk("wr_add", 64'(bus.s_add_o), 64'h1A10_0004);
        chk("wr_we_n", 64'(bus.s_we_n_o), 64'd0);
        chk("wr_wdata", 64'(bus.s_wdata_o), 64'h1234_5678);
        chk("wr_be", 64'(bus.s_be_o), 64'hF);
        chk("wr_id", 64'(bus.s_ID_o), 64'h2A);
        chk("wr_aux", 64'(bus.s_aux_o), 64'h155);
        tick();
        bus.m_req_i     = '0;
        bus.s_gnt_i     = 1'b0;
        bus.s_r_valid_i = 1'b1;
        bus.s_r_opc_i   = 1'b1;
        bus.s_r_ID_i    = 10'h2A;
        bus.s_r_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("wr_rvalid", 64'(bus.m_r_valid_o), 64'b1000);
        chk("wr_opc", 64'(bus.m_r_opc_o), 64'd1);
        chk("wr_rid", 64'(bus.m_r_ID_o), 64'h2A);
        chk("wr_rdata", 64'(bus.m_r_rdata_o), 64'hDEAD_BEEF);
        chk("wr_rr", 64'(dut.rr_q), 64'd0);
        tick();
        clear_inputs();

        // Randomized run against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_busy = 0; m_pres = -1; m_rr = 0; m_owner = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.m_req_i[i]) bus.m_req_i[i] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 15) == 0) bus.m_req_i[i] = 1'b0;
                bus.m_add_i[i]  = $urandom;
                bus.m_we_n_i[i] = 1'($urandom);
            end
            bus.s_gnt_i     = 1'($urandom);
            bus.s_r_valid_i = ($urandom_range(0, 2) == 0);
            bus.s_r_rdata_i = $urandom;

            e_sreq = 1'b0; e_gnt = '0; e_rv = '0; e_sel = -1;
            if (rst) begin
                // outputs all forced low; state cleared below
            end else if (m_busy != 0) begin
                if (bus.s_r_valid_i) e_rv = 4'(1 << m_owner);
            end else if (m_pres >= 0) begin
                e_sel = m_pres;
                e_sreq = bus.m_req_i[m_pres];
                if (e_sreq && bus.s_gnt_i) e_gnt = 4'(1 << m_pres);
            end else begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && bus.m_req_i[(m_rr + k) % N]) w = (m_rr + k) % N;
                if (w >= 0) begin
                    e_sel = w;
                    e_sreq = 1'b1;
                    if (bus.s_gnt_i) e_gnt = 4'(1 << w);
                end
            end

            #2;
            chk("rnd_s_req", 64'(bus.s_req_o), 64'(e_sreq));
            chk("rnd_gnt", 64'(bus.m_gnt_o), 64'(e_gnt));
            chk("rnd_rvalid", 64'(bus.m_r_valid_o), 64'(e_rv));
            chk("rnd_rr", 64'(dut.rr_q), 64'(m_rr));
            chk("rnd_rdata", 64'(bus.m_r_rdata_o), 64'(bus.s_r_rdata_i));
            if (e_sreq) begin
                chk("rnd_addr", 64'(bus.s_add_o), 64'(bus.m_add_i[e_sel]));
                chk("rnd_we_n", 64'(bus.s_we_n_o), 64'(bus.m_we_n_i[e_sel]));
            end

            if (rst) begin
                m_busy = 0; m_pres = -1; m_rr = 0; m_owner = 0;
            end else if (m_busy != 0) begin
                if (bus.s_r_valid_i) m_busy = 0;
            end else if (e_sel >= 0) begin
                if (!e_sreq) m_pres = -1;
                else if (bus.s_gnt_i) begin
                    m_busy = 1; m_owner = e_sel; m_rr = (e_sel + 1) % N; m_pres = -1;
                end else m_pres = e_sel;
            end else m_pres = -1;

            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
